// File: rtl/lv_bist_seq.sv
// lv_bist_seq: LV logic BIST sequencer with run timeout, retry gap and held verdict/fail code/attempt count.
// Optional macro LV_BIST_SEQ_STICKY_FAIL_EN: fail code accumulates every attempt code of a run instead of the last only.
module lv_bist_seq #(
  parameter int unsigned BIST_RETRY_NUM = 2,
  parameter int unsigned BIST_GAP_CYC   = 16,
  parameter int unsigned BIST_WAIT_TH   = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bist_start,
  input  logic       i_bist_abort,
  output logic       o_bist_en,
  input  logic       i_lv_bist_done,
  input  logic       i_owt_bist_rult,
  input  logic       i_scan_reg_bist_rult,
  output logic       o_bist_busy,
  output logic       o_bist_cmplt,
  output logic       o_bist_pass,
  output logic [2:0] o_bist_fail_code,
  output logic [2:0] o_bist_att_cnt
);

  localparam int unsigned WaitW = $clog2(BIST_WAIT_TH);
  localparam int unsigned GapW  = $clog2(BIST_GAP_CYC + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(BIST_WAIT_TH - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(BIST_GAP_CYC - 1);
  localparam logic [3:0]       RetryLim = 4'(BIST_RETRY_NUM);

  typedef enum logic [2:0] {IDLE, RUN, CHECK, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] waitCnt_q, waitCnt_d;
  logic [GapW-1:0]  gapCnt_q, gapCnt_d;
  logic [3:0]       attCnt_q, attCnt_d;
  logic             tmo_q, tmo_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             cmplt_q, cmplt_d;
  logic             pass_q, pass_d;
  logic [2:0]       failCode_q, failCode_d;
  logic [2:0]       attOut_q, attOut_d;
  logic [2:0]       attCode;
  logic             abortHit;

  // A timed-out attempt reports only the timeout bit; result flags are meaningless then.
  assign attCode  = tmo_q ? 3'b100 : {1'b0, ~i_scan_reg_bist_rult, ~i_owt_bist_rult};
  assign abortHit = i_bist_abort && (state_q != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      gapCnt_q   <= '0;
      attCnt_q   <= '0;
      tmo_q      <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      cmplt_q    <= 1'b0;
      pass_q     <= 1'b0;
      failCode_q <= '0;
      attOut_q   <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      gapCnt_q   <= gapCnt_d;
      attCnt_q   <= attCnt_d;
      tmo_q      <= tmo_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      cmplt_q    <= cmplt_d;
      pass_q     <= pass_d;
      failCode_q <= failCode_d;
      attOut_q   <= attOut_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_bist_start && !i_bist_abort) state_d = RUN;
      RUN:     if (i_lv_bist_done || (waitCnt_q == WaitLast)) state_d = CHECK;
      CHECK: begin
        if (attCode == 3'b000)        state_d = DONE;
        else if (attCnt_q <= RetryLim) state_d = GAP;
        else                           state_d = DONE;
      end
      GAP:     if (gapCnt_q == GapLast) state_d = RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abortHit) state_d = IDLE;
  end

  always_comb begin
    waitCnt_d  = waitCnt_q;
    gapCnt_d   = gapCnt_q;
    attCnt_d   = attCnt_q;
    tmo_d      = tmo_q;
    pass_d     = pass_q;
    failCode_d = failCode_q;
    unique case (state_q)
      IDLE: begin
        if (state_d == RUN) begin
          pass_d     = 1'b0;
          failCode_d = '0;
          attCnt_d   = 4'd1;
          waitCnt_d  = '0;
          tmo_d      = 1'b0;
        end
      end
      RUN: begin
        if (waitCnt_q != {WaitW{1'b1}}) waitCnt_d = waitCnt_q + 1'b1;
        if ((state_d == CHECK) && !i_lv_bist_done) tmo_d = 1'b1;
      end
      CHECK: begin
`ifdef LV_BIST_SEQ_STICKY_FAIL_EN
        failCode_d = failCode_q | attCode;
`else
        failCode_d = attCode;
`endif
        if (state_d == DONE) pass_d = (attCode == 3'b000);
        if (state_d == GAP) begin
          if (attCnt_q != 4'hF) attCnt_d = attCnt_q + 4'd1;
          gapCnt_d = '0;
        end
      end
      GAP: begin
        if (state_d == RUN) begin
          waitCnt_d = '0;
          tmo_d     = 1'b0;
        end else if (gapCnt_q != {GapW{1'b1}}) begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Abort discards the run's verdict but keeps the attempt count for diagnosis.
    if (abortHit) begin
      pass_d     = 1'b0;
      failCode_d = '0;
      attCnt_d   = attCnt_q;
    end
    en_d     = (state_d == RUN) || (state_d == CHECK);
    busy_d   = (state_d == RUN) || (state_d == CHECK) || (state_d == GAP);
    cmplt_d  = (state_d == DONE);
    attOut_d = (attCnt_d > 4'd7) ? 3'd7 : attCnt_d[2:0];
  end

  assign o_bist_en        = en_q;
  assign o_bist_busy      = busy_q;
  assign o_bist_cmplt     = cmplt_q;
  assign o_bist_pass      = pass_q;
  assign o_bist_fail_code = failCode_q;
  assign o_bist_att_cnt   = attOut_q;

endmodule
